matmul_seq_param: RTL and testbench

- Parametrised sequential signed matrix multiplier, C = A x B, for NxN matrices of DW-bit two's-complement elements.
- Computes one multiply-accumulate per clock through a single MAC datapath.
- Adds a start/busy input handshake and a valid/ready output handshake with back-pressure.
- Keeps a full-precision accumulator, formats each result element with selectable wrap or saturate, and flags overflow.
- Sits as the reusable compute core behind board-level wrappers (switch/LED or UART front ends).

---
 rtl/matmul_seq_param_if.sv | 22 ++
 rtl/matmul_seq_param.sv | 163 ++++++++++++++++
 tb/tb_matmul_seq_param.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_seq_param_if.sv
// Bus bundle for the sequential matrix multiplier: start/busy request side and
// valid/ready result side. Clock and reset stay outside as plain ports.
interface matmul_seq_param_if #(
   parameter int N     = 3,
   parameter int DW    = 8,
   parameter int OUT_W = 8
);
   logic                   start;
   logic [N*N*DW-1:0]      A;
   logic [N*N*DW-1:0]      B;
   logic                   busy;
   logic [N*N*OUT_W-1:0]   C;
   logic                   c_valid;
   logic                   c_ready;
   logic                   ovf;

   // start is taken only when busy is low (A/B sampled on that edge); a result
   // transfers on the edge where c_valid && c_ready, and C/ovf/c_valid hold
   // stable while c_valid is high and c_ready is low.
   modport master (output start, A, B, c_ready, input busy, C, c_valid, ovf);
   modport slave  (input start, A, B, c_ready, output busy, C, c_valid, ovf);
endinterface

// File: rtl/matmul_seq_param.sv
// Sequential signed NxN matrix multiplier: one MAC per clock, k innermost,
// full-precision accumulator, wrap or saturate formatting with sticky overflow.
module matmul_seq_param #(
   parameter int N        = 3,
   parameter int DW       = 8,
   parameter int OUT_W    = 8,
   parameter int SAT_MODE = 0
) (
   input  logic                Clock,
   input  logic                reset,
   matmul_seq_param_if.slave   bus,
   output logic [1:0]          state_o
);
   localparam int ACC_W = 2*DW + $clog2(N);
   localparam int IW    = $clog2(N);
   localparam int EXT_W = (OUT_W > ACC_W) ? OUT_W : ACC_W;
   localparam longint MAX_L = (longint'(1) <<< (OUT_W-1)) - 1;
   localparam longint MIN_L = -(longint'(1) <<< (OUT_W-1));
   localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'(MAX_L);
   localparam logic signed [EXT_W-1:0] MIN_V = EXT_W'(MIN_L);
   localparam logic [IW-1:0] LAST = IW'(N-1);

   typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, DONE = 2'd2} state_t;

   state_t                    state_q, state_d;
   logic signed [DW-1:0]      a_q [N][N];
   logic signed [DW-1:0]      a_d [N][N];
   logic signed [DW-1:0]      b_q [N][N];
   logic signed [DW-1:0]      b_d [N][N];
   logic [IW-1:0]             i_q, i_d, j_q, j_d, k_q, k_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic [N*N*OUT_W-1:0]      res_q, res_d, c_q, c_d;
   logic                      ovf_int_q, ovf_int_d;
   logic                      ovf_q, ovf_d;
   logic                      busy_q, busy_d;
   logic                      c_valid_q, c_valid_d;

   logic signed [2*DW-1:0]    prod;
   logic signed [ACC_W-1:0]   sum;
   logic signed [EXT_W-1:0]   sum_ext;
   logic                      sum_hi, sum_lo;
   logic [OUT_W-1:0]          elem;
   int                        res_idx;

   // Datapath: the sum is widened so the range test works even when OUT_W >= ACC_W.
   always_comb begin
      prod    = a_q[i_q][k_q] * b_q[k_q][j_q];
      sum     = acc_q + ACC_W'(prod);
      sum_ext = EXT_W'(sum);
      sum_hi  = sum_ext > MAX_V;
      sum_lo  = sum_ext < MIN_V;
      if (SAT_MODE != 0 && sum_hi)      elem = MAX_V[OUT_W-1:0];
      else if (SAT_MODE != 0 && sum_lo) elem = MIN_V[OUT_W-1:0];
      else                              elem = sum_ext[OUT_W-1:0];
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      i_d       = i_q;
      j_d       = j_q;
      k_d       = k_q;
      acc_d     = acc_q;
      res_d     = res_q;
      c_d       = c_q;
      ovf_int_d = ovf_int_q;
      ovf_d     = ovf_q;
      busy_d    = busy_q;
      c_valid_d = c_valid_q;
      res_idx   = int'(i_q) * N + int'(j_q);
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               for (int r = 0; r < N; r++) begin
                  for (int c = 0; c < N; c++) begin
                     a_d[r][c] = bus.A[(r*N+c)*DW +: DW];
                     b_d[r][c] = bus.B[(r*N+c)*DW +: DW];
                  end
               end
               acc_d     = '0;
               i_d       = '0;
               j_d       = '0;
               k_d       = '0;
               ovf_int_d = 1'b0;
               busy_d    = 1'b1;
               state_d   = MAC;
            end
         end
         MAC: begin
            if (k_q == LAST) begin
               res_d[res_idx*OUT_W +: OUT_W] = elem;
               acc_d     = '0;
               ovf_int_d = ovf_int_q | sum_hi | sum_lo;
               k_d       = '0;
               if (j_q == LAST) begin
                  j_d = '0;
                  if (i_q == LAST) begin
                     i_d       = '0;
                     c_d       = res_d;
                     ovf_d     = ovf_int_d;
                     c_valid_d = 1'b1;
                     state_d   = DONE;
                  end else begin
                     i_d = i_q + 1'b1;
                  end
               end else begin
                  j_d = j_q + 1'b1;
               end
            end else begin
               acc_d = sum;
               k_d   = k_q + 1'b1;
            end
         end
         DONE: begin
            if (bus.c_ready) begin
               c_valid_d = 1'b0;
               busy_d    = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         a_q       <= '{default: '0};
         b_q       <= '{default: '0};
         i_q       <= '0;
         j_q       <= '0;
         k_q       <= '0;
         acc_q     <= '0;
         res_q     <= '0;
         c_q       <= '0;
         ovf_int_q <= 1'b0;
         ovf_q     <= 1'b0;
         busy_q    <= 1'b0;
         c_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         i_q       <= i_d;
         j_q       <= j_d;
         k_q       <= k_d;
         acc_q     <= acc_d;
         res_q     <= res_d;
         c_q       <= c_d;
         ovf_int_q <= ovf_int_d;
         ovf_q     <= ovf_d;
         busy_q    <= busy_d;
         c_valid_q <= c_valid_d;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.C       = c_q;
   assign bus.c_valid = c_valid_q;
   assign bus.ovf     = ovf_q;
   assign state_o     = state_q;
endmodule

// File: tb/tb_matmul_seq_param.sv
// Bench for matmul_seq_param: two 3x3 8-bit cores (wrap and saturate) driven in
// lockstep, plus a 4x4 16-bit full-precision core checked against an arithmetic model.
module tb_matmul_seq_param;
   logic Clock = 1'b0;
   logic reset = 1'b1;
   logic [1:0] st_w, st_s, st_4;

   int n_checks = 0;
   int n_fail   = 0;

   logic [543:0] exp_q[$];

   matmul_seq_param_if #(.N(3), .DW(8),  .OUT_W(8))  if_w ();
   matmul_seq_param_if #(.N(3), .DW(8),  .OUT_W(8))  if_s ();
   matmul_seq_param_if #(.N(4), .DW(16), .OUT_W(34)) if_4 ();

   matmul_seq_param #(.N(3), .DW(8), .OUT_W(8), .SAT_MODE(0)) u_wrap (
      .Clock(Clock), .reset(reset), .bus(if_w.slave), .state_o(st_w));
   matmul_seq_param #(.N(3), .DW(8), .OUT_W(8), .SAT_MODE(1)) u_sat (
      .Clock(Clock), .reset(reset), .bus(if_s.slave), .state_o(st_s));
   matmul_seq_param #(.N(4), .DW(16), .OUT_W(34), .SAT_MODE(0)) u_wide (
      .Clock(Clock), .reset(reset), .bus(if_4.slave), .state_o(st_4));

   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [543:0] act, input logic [543:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- stimulus helpers and reference models ----------------
   function automatic logic [71:0] fill3(input logic [7:0] v);
      logic [71:0] m;
      for (int e = 0; e < 9; e++) m[e*8 +: 8] = v;
      return m;
   endfunction

   function automatic logic [71:0] seq3(input int scale);
      logic [71:0] m;
      for (int e = 0; e < 9; e++) m[e*8 +: 8] = 8'((e + 1) * scale);
      return m;
   endfunction

   function automatic logic [71:0] ident3(input int scale);
      logic [71:0] m = '0;
      for (int d = 0; d < 3; d++) m[(d*3+d)*8 +: 8] = 8'(scale);
      return m;
   endfunction

   function automatic logic [71:0] rand3();
      logic [71:0] m;
      for (int e = 0; e < 9; e++) m[e*8 +: 8] = 8'($urandom());
      return m;
   endfunction

   function automatic logic [255:0] rand4();
      logic [255:0] m;
      for (int e = 0; e < 16; e++) m[e*16 +: 16] = 16'($urandom());
      return m;
   endfunction

   // Plain dot products on 64-bit integers, then range handling on the result.
   function automatic void model3(input logic [71:0] a, input logic [71:0] b, input bit sat,
                                  output logic [71:0] c, output logic ov);
      c  = '0;
      ov = 1'b0;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            longint s = 0;
            for (int k = 0; k < 3; k++)
               s += longint'($signed(a[(i*3+k)*8 +: 8])) * longint'($signed(b[(k*3+j)*8 +: 8]));
            if (s > 127 || s < -128) ov = 1'b1;
            if (sat && s > 127)       c[(i*3+j)*8 +: 8] = 8'h7f;
            else if (sat && s < -128) c[(i*3+j)*8 +: 8] = 8'h80;
            else                      c[(i*3+j)*8 +: 8] = s[7:0];
         end
      end
   endfunction

   function automatic void model4(input logic [255:0] a, input logic [255:0] b,
                                  output logic [543:0] c, output logic ov);
      c  = '0;
      ov = 1'b0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            longint s = 0;
            for (int k = 0; k < 4; k++)
               s += longint'($signed(a[(i*4+k)*16 +: 16])) * longint'($signed(b[(k*4+j)*16 +: 16]));
            if (s > 64'sh1_FFFF_FFFF || s < -64'sh2_0000_0000) ov = 1'b1;
            c[(i*4+j)*34 +: 34] = s[33:0];
         end
      end
   endfunction

   // ---------------- drivers ----------------
   task automatic set3(input logic [71:0] a, input logic [71:0] b, input logic st, input logic rdy);
      if_w.A = a;  if_s.A = a;
      if_w.B = b;  if_s.B = b;
      if_w.start = st;   if_s.start = st;
      if_w.c_ready = rdy; if_s.c_ready = rdy;
   endtask

   task automatic wait_valid3(output int lat);
      lat = 0;
      while (!if_w.c_valid && lat < 200) begin
         @(posedge Clock); #1;
         lat++;
      end
   endtask

   // Full transaction on both 3x3 cores, A/B scrambled right after acceptance.
   task automatic run3(input logic [71:0] a, input logic [71:0] b,
                       output logic [71:0] cw, output logic [71:0] cs,
                       output logic ow, output logic os);
      int lat;
      @(negedge Clock);
      set3(a, b, 1'b1, 1'b1);
      @(posedge Clock); #1;
      check("busy_after_accept", {if_w.busy, if_s.busy}, 2'b11);
      set3(rand3(), rand3(), 1'b0, 1'b1);
      wait_valid3(lat);
      check("latency_n3", lat, 27);
      check("sat_valid_aligned", if_s.c_valid, 1'b1);
      cw = if_w.C;  cs = if_s.C;
      ow = if_w.ovf; os = if_s.ovf;
      @(posedge Clock); #1;
      check("idle_after_handshake", {if_w.busy, if_s.busy, if_w.c_valid, if_s.c_valid}, 4'b0000);
   endtask

   task automatic run4(input logic [255:0] a, input logic [255:0] b);
      int lat;
      logic [543:0] exp_c;
      logic exp_ov;
      model4(a, b, exp_c, exp_ov);
      exp_q.push_back(exp_c);
      @(negedge Clock);
      if_4.A = a; if_4.B = b; if_4.start = 1'b1; if_4.c_ready = 1'b1;
      @(posedge Clock); #1;
      if_4.start = 1'b0;
      if_4.A = rand4(); if_4.B = rand4();
      lat = 0;
      while (!if_4.c_valid && lat < 300) begin
         @(posedge Clock); #1;
         lat++;
      end
      check("latency_n4", lat, 64);
      check("c_n4", if_4.C, exp_q.pop_front());
      check("ovf_n4", if_4.ovf, exp_ov);
      @(posedge Clock); #1;
      check("idle_n4", {if_4.busy, if_4.c_valid}, 2'b00);
   endtask

   typedef struct {
      string       name;
      logic [71:0] a;
      logic [71:0] b;
      logic [71:0] exp_w;
      logic [71:0] exp_s;
      logic        ov_w;
      logic        ov_s;
   } vec_t;

   initial begin
      vec_t vecs[5];
      logic [71:0] cw, cs, mw, ms;
      logic ow, os, mow, mos;
      int lat;

      vecs[0] = '{"identity", ident3(1), seq3(1), seq3(1), seq3(1), 1'b0, 1'b0};
      vecs[1] = '{"all_127", fill3(8'h7f), fill3(8'h7f), fill3(8'h03), fill3(8'h7f), 1'b1, 1'b1};
      vecs[2] = '{"neg128_x_127", fill3(8'h80), fill3(8'h7f), fill3(8'h80), fill3(8'h80), 1'b1, 1'b1};
      vecs[3] = '{"neg128_sq", fill3(8'h80), fill3(8'h80), fill3(8'h00), fill3(8'h7f), 1'b1, 1'b1};
      vecs[4] = '{"two_identity", ident3(2), seq3(1), seq3(2), seq3(2), 1'b0, 1'b0};

      set3('0, '0, 1'b0, 1'b0);
      if_4.A = '0; if_4.B = '0; if_4.start = 1'b0; if_4.c_ready = 1'b0;

      // Reset state
      #23;
      check("rst_w", {if_w.busy, if_w.c_valid, if_w.ovf, if_w.C}, '0);
      check("rst_s", {if_s.busy, if_s.c_valid, if_s.ovf, if_s.C}, '0);
      check("rst_4", {if_4.busy, if_4.c_valid, if_4.ovf, if_4.C}, '0);
      check("rst_state", {st_w, st_s, st_4}, '0);
      @(negedge Clock);
      reset = 1'b0;

      // Table-driven vectors
      for (int t = 0; t < 5; t++) begin
         run3(vecs[t].a, vecs[t].b, cw, cs, ow, os);
         check({vecs[t].name, "_c_wrap"}, cw, vecs[t].exp_w);
         check({vecs[t].name, "_c_sat"}, cs, vecs[t].exp_s);
         check({vecs[t].name, "_ovf"}, {ow, os}, {vecs[t].ov_w, vecs[t].ov_s});
      end

      // Back-pressure with start pulses and A/B churn while results are held
      @(negedge Clock);
      set3(fill3(8'h7f), fill3(8'h7f), 1'b1, 1'b0);
      @(posedge Clock); #1;
      set3(fill3(8'h7f), fill3(8'h7f), 1'b0, 1'b0);
      wait_valid3(lat);
      check("bp_latency", lat, 27);
      for (int c = 0; c < 10; c++) begin
         @(negedge Clock);
         set3(rand3(), rand3(), 1'b1, 1'b0);
         @(posedge Clock); #1;
         check("bp_hold_valid", {if_w.c_valid, if_s.c_valid, if_w.busy, if_s.busy}, 4'b1111);
         check("bp_hold_c", {if_w.C, if_s.C}, {fill3(8'h03), fill3(8'h7f)});
         check("bp_hold_ovf", {if_w.ovf, if_s.ovf}, 2'b11);
      end
      @(negedge Clock);
      set3(seq3(1), seq3(1), 1'b1, 1'b1);
      @(posedge Clock); #1;
      check("bp_start_with_ready", {if_w.busy, if_w.c_valid, st_w, st_s}, '0);
      set3(seq3(1), seq3(1), 1'b0, 1'b1);
      @(posedge Clock); #1;
      check("bp_single_handshake", {if_w.busy, if_s.busy, if_w.c_valid, if_s.c_valid}, 4'b0000);
      check("bp_c_kept", {if_w.C, if_w.ovf}, {fill3(8'h03), 1'b1});
      run3(ident3(1), seq3(1), cw, cs, ow, os);
      check("bp_next_run", {cw, cs, ow, os}, {seq3(1), seq3(1), 2'b00});

      // Reset in the middle of MAC
      @(negedge Clock);
      set3(fill3(8'h7f), fill3(8'h80), 1'b1, 1'b1);
      @(posedge Clock); #1;
      set3(fill3(8'h7f), fill3(8'h80), 1'b0, 1'b1);
      repeat (12) @(posedge Clock);
      #3 reset = 1'b1;
      #1;
      check("abort_outputs_w", {if_w.busy, if_w.c_valid, if_w.ovf, if_w.C}, '0);
      check("abort_outputs_s", {if_s.busy, if_s.c_valid, if_s.ovf, if_s.C}, '0);
      check("abort_state", {st_w, st_s}, 4'b0000);
      @(negedge Clock);
      reset = 1'b0;
      run3(ident3(2), seq3(1), cw, cs, ow, os);
      check("after_abort", {cw, cs, ow, os}, {seq3(2), seq3(2), 2'b00});

      // Random 3x3 against the model
      for (int r = 0; r < 20; r++) begin
         logic [71:0] ra, rb;
         ra = rand3();
         rb = rand3();
         model3(ra, rb, 1'b0, mw, mow);
         model3(ra, rb, 1'b1, ms, mos);
         run3(ra, rb, cw, cs, ow, os);
         check("rand3_c_wrap", cw, mw);
         check("rand3_c_sat", cs, ms);
         check("rand3_ovf", {ow, os}, {mow, mos});
      end

      // Random 4x4 full precision
      for (int r = 0; r < 100; r++) run4(rand4(), rand4());
      check("scoreboard_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
